// File: rtl/y_buf_argmax_reader.sv
// y_buf_argmax_reader: reads NUM_CLASS FP32 scores per image from the y buffer and streams the arg-max index.
// Defining YRD_MAX_SCORE_EN adds cls_score_o carrying the winning score bits.
module y_buf_argmax_reader #(
   parameter int IN_IMG_NUM = 1,
   parameter int NUM_CLASS = 10,
   parameter int Y_BUF_DATA_WIDTH = 32,
   parameter int Y_BUF_DEPTH = 10*IN_IMG_NUM*4,
   parameter int ADDR_STEP = 4,
   parameter int IMG_W = (IN_IMG_NUM > 1) ? $clog2(IN_IMG_NUM) : 1,
   localparam int AW = $clog2(Y_BUF_DEPTH),
   localparam int KW = $clog2(NUM_CLASS),
   localparam int DW = Y_BUF_DATA_WIDTH
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          y_buf_en,
   output logic          y_buf_wr_en,
   output logic [AW-1:0] y_buf_addr,
   input  logic [DW-1:0] y_buf_data_i,
   output logic          cls_valid_o,
   input  logic          cls_ready_i,
   output logic [KW-1:0] cls_idx_o,
   output logic [IMG_W-1:0] cls_img_o
`ifdef YRD_MAX_SCORE_EN
   ,output logic [DW-1:0] cls_score_o
`endif
);
   typedef enum logic [2:0] {IDLE, RD, DRAIN, OUT, FIN} state_t;
   state_t state;
   logic [KW-1:0] k, rd_k, best, best_n;
   logic [IMG_W-1:0] img;
   logic rd_v, rd_first, upd;
   logic [DW-1:0] key, max_key;
   // Sign-magnitude float mapped to an unsigned key that orders like the float value
   assign key = y_buf_data_i[DW-1] ? ~y_buf_data_i : {1'b1, y_buf_data_i[DW-2:0]};
   assign upd = rd_v && (rd_first || key > max_key);
   assign best_n = upd ? rd_k : best;
   assign y_buf_wr_en = 1'b0;
`ifdef YRD_MAX_SCORE_EN
   logic [DW-1:0] max_x, max_x_n;
   assign max_x_n = upd ? y_buf_data_i : max_x;
   assign max_key = max_x[DW-1] ? ~max_x : {1'b1, max_x[DW-2:0]};
`else
   logic [DW-1:0] max_key_q;
   assign max_key = max_key_q;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         y_buf_en <= 1'b0;
         y_buf_addr <= '0;
         cls_valid_o <= 1'b0;
         cls_idx_o <= '0;
         cls_img_o <= '0;
         k <= '0;
         img <= '0;
         rd_v <= 1'b0;
         rd_first <= 1'b0;
         rd_k <= '0;
         best <= '0;
`ifdef YRD_MAX_SCORE_EN
         max_x <= '0;
         cls_score_o <= '0;
`else
         max_key_q <= '0;
`endif
      end else begin
         rd_v <= y_buf_en;
         rd_first <= y_buf_en && (k == '0);
         rd_k <= k;
         best <= best_n;
`ifdef YRD_MAX_SCORE_EN
         max_x <= max_x_n;
`else
         max_key_q <= upd ? key : max_key_q;
`endif
         case (state)
            IDLE: if (start_i) begin
               state <= RD;
               busy_o <= 1'b1;
               img <= '0;
               k <= '0;
               y_buf_addr <= '0;
               y_buf_en <= 1'b1;
            end
            RD: if (k == KW'(NUM_CLASS-1)) begin
               state <= DRAIN;
               y_buf_en <= 1'b0;
            end else begin
               k <= k + KW'(1);
               y_buf_addr <= y_buf_addr + AW'(ADDR_STEP);
            end
            DRAIN: begin
               state <= OUT;
               cls_valid_o <= 1'b1;
               cls_idx_o <= best_n;
               cls_img_o <= img;
`ifdef YRD_MAX_SCORE_EN
               cls_score_o <= max_x_n;
`endif
            end
            OUT: if (cls_ready_i) begin
               cls_valid_o <= 1'b0;
               if (img == IMG_W'(IN_IMG_NUM-1)) begin
                  state <= FIN;
                  done_o <= 1'b1;
                  busy_o <= 1'b0;
               end else begin
                  // Next image starts right after the last address of this one
                  state <= RD;
                  img <= img + IMG_W'(1);
                  k <= '0;
                  y_buf_addr <= y_buf_addr + AW'(ADDR_STEP);
                  y_buf_en <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               done_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_y_buf_argmax_reader.sv
// tb_y_buf_argmax_reader: directed checks of arg-max reading with one-image and two-image instances.
module tb_y_buf_argmax_reader;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   logic start1 = 0, busy1, done1, en1, wr1, valid1, ready1 = 1;
   logic [5:0] addr1;
   logic [31:0] data1;
   logic [3:0] idx1;
   logic [0:0] img1;
   logic start2 = 0, busy2, done2, en2, wr2, valid2, ready2 = 0;
   logic [6:0] addr2;
   logic [31:0] data2;
   logic [3:0] idx2;
   logic [0:0] img2;
   logic [31:0] mem [20];
   logic [6:0] aq1[$], aq2[$];
   int checks = 0, errors = 0, dn2 = 0;
   y_buf_argmax_reader u1 (
      .clk(clk), .rst(rst), .start_i(start1), .busy_o(busy1), .done_o(done1),
      .y_buf_en(en1), .y_buf_wr_en(wr1), .y_buf_addr(addr1), .y_buf_data_i(data1),
      .cls_valid_o(valid1), .cls_ready_i(ready1), .cls_idx_o(idx1), .cls_img_o(img1));
   y_buf_argmax_reader #(.IN_IMG_NUM(2)) u2 (
      .clk(clk), .rst(rst), .start_i(start2), .busy_o(busy2), .done_o(done2),
      .y_buf_en(en2), .y_buf_wr_en(wr2), .y_buf_addr(addr2), .y_buf_data_i(data2),
      .cls_valid_o(valid2), .cls_ready_i(ready2), .cls_idx_o(idx2), .cls_img_o(img2));
   always @(posedge clk) begin
      if (en1) data1 <= mem[addr1 >> 2];
      if (en2) data2 <= mem[addr2 >> 2];
   end
   always @(negedge clk) begin
      if (en1) aq1.push_back({1'b0, addr1});
      if (en2) aq2.push_back(addr2);
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic ld(input int b, input logic [319:0] v);
      for (int i = 0; i < 10; i++) mem[b+i] = v[319-32*i -: 32];
   endtask
   task automatic run1(input string t, input logic [3:0] ei, input bit dbl);
      int vc, dc, a0;
      vc = 0; dc = 0; a0 = aq1.size();
      @(negedge clk) start1 = 1;
      @(negedge clk) start1 = 0;
      for (int n = 1; n <= 30 && dc == 0; n++) begin
         start1 = dbl && n == 3;
         if (valid1 && vc == 0) begin
            vc = n;
            chk({t, ".idx"}, 32'(idx1), 32'(ei));
            chk({t, ".img"}, 32'(img1), 0);
         end
         if (done1) begin
            dc = n;
            chk({t, ".busy_at_done"}, 32'(busy1), 0);
         end
         @(negedge clk);
      end
      #1;
      chk({t, ".vcyc"}, vc, 12);
      chk({t, ".dcyc"}, dc, 13);
      chk({t, ".nrd"}, aq1.size() - a0, 10);
      for (int i = 0; i < 10; i++) chk($sformatf("%s.addr%0d", t, i), 32'(aq1[a0+i]), 4*i);
   endtask
   task automatic wait_v2(input string t);
      int n;
      n = 0;
      while (!valid2 && n < 40) begin
         if (done2) dn2++;
         @(negedge clk);
         n++;
      end
      chk({t, ".timeout"}, 32'(valid2), 1);
   endtask
   initial begin
      int a0, dc;
      for (int i = 0; i < 20; i++) mem[i] = '0;
      repeat (2) @(negedge clk);
      chk("rst.u1", {busy1, done1, en1, wr1, addr1, valid1, idx1, img1}, 0);
      chk("rst.u2", {busy2, done2, en2, wr2, addr2, valid2, idx2, img2}, 0);
      rst = 0;
      ld(0, {32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD, 32'h3F000000,
             32'h3F19999A, 32'h3F333333, 32'h3F4CCCCD, 32'h3F666666, 32'h3D4CCCCD});
      run1("t1", 4'd8, 0);
      ld(0, {32'hC0A00000, {2{32'hC1100000}}, 32'hBF800000, {6{32'hC1100000}}});
      run1("neg", 4'd3, 0);
      ld(0, {32'h80000000, 32'h00000000, {8{32'hBF800000}}});
      run1("zero", 4'd1, 0);
      ld(0, {{2{32'h0}}, 32'h3FC00000, {4{32'h0}}, 32'h3FC00000, {2{32'h0}}});
      run1("tie", 4'd2, 0);
      ld(0, {32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD, 32'h3F000000,
             32'h3F19999A, 32'h3F333333, 32'h3F4CCCCD, 32'h3F666666, 32'h3D4CCCCD});
      run1("dblstart", 4'd8, 1);
      ld(10, {{5{32'hC1100000}}, 32'h40000000, {4{32'hC1100000}}});
      a0 = aq2.size();
      @(negedge clk) start2 = 1;
      @(negedge clk) start2 = 0;
      wait_v2("u2.img0");
      chk("u2.img0", {valid2, img2, idx2}, {1'b1, 1'b0, 4'd8});
      repeat (5) begin
         @(negedge clk);
         chk("u2.stall", {valid2, en2, img2, idx2}, {1'b1, 1'b0, 1'b0, 4'd8});
      end
      ready2 = 1;
      @(negedge clk) ready2 = 0;
      wait_v2("u2.img1");
      #1;
      chk("u2.nrd", aq2.size() - a0, 20);
      chk("u2.addr10", 32'(aq2[a0+10]), 40);
      chk("u2.addr19", 32'(aq2[a0+19]), 76);
      chk("u2.res1", {valid2, img2, idx2}, {1'b1, 1'b1, 4'd5});
      ready2 = 1;
      repeat (5) begin
         @(negedge clk);
         if (done2) dn2++;
      end
      chk("u2.dones", dn2, 1);
      chk("u2.idle", {busy2, valid2, en2}, 0);
      @(negedge clk) start1 = 1;
      @(negedge clk) start1 = 0;
      repeat (3) @(negedge clk);
      chk("rst.pre", {busy1, en1}, 2'b11);
      rst = 1;
      #1;
      chk("rst.mid", {busy1, done1, en1, wr1, addr1, valid1, idx1, img1}, 0);
      @(negedge clk) rst = 0;
      dc = 0;
      repeat (20) begin
         @(negedge clk);
         if (done1 || en1 || busy1 || valid1) dc++;
      end
      chk("rst.idle", dc, 0);
      ld(0, {{2{32'h0}}, 32'h3FC00000, {4{32'h0}}, 32'h3FC00000, {2{32'h0}}});
      run1("fresh", 4'd2, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
